// File: rtl/u_dly_coarse_prog.sv
// Programmable coarse delay line: delays a DW-bit stream by sel*T_UNIT enabled
// clock edges through a clock-enabled register chain, with a select guard window.
//
// state  | meaning
// IDLE   | select stable, outputs track the tap, new loads accepted
// GUARD1 | first cycle after a load, outputs held, loads ignored
// GUARD2 | second cycle after a load, outputs held, loads ignored
module u_dly_coarse_prog #(
  parameter int DW     = 1,
  parameter int SEL_W  = 3,
  parameter int T_UNIT = 60
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [DW-1:0]    i_in,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_sel_load,
  output logic [DW-1:0]    o_out,
  output logic             o_vld,
  output logic [SEL_W-1:0] o_sel_cur,
  output logic             o_busy
);

  localparam int NSTEP = 1 << SEL_W;
  localparam int DEPTH = (NSTEP - 1) * T_UNIT;
  localparam int CW    = $clog2(DEPTH + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GUARD1 = 2'd1,
    GUARD2 = 2'd2
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] sel_cur;
  logic             busy;
  logic             guard;

  logic [DW-1:0]    d [DEPTH];
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    thr;
  logic [DW-1:0]    tap;
  logic             shift;

  assign guard = (state != IDLE);
  assign shift = i_en && !i_flush;

  // Select FSM; busy is registered alongside the state so it needs no decode.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      sel_cur <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_sel_load) begin
            sel_cur <= i_sel;
            state   <= GUARD1;
            busy    <= 1'b1;
          end
        end
        GUARD1: begin
          state <= GUARD2;
          busy  <= 1'b1;
        end
        GUARD2: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int k = 0; k < DEPTH; k++) d[k] <= '0;
    end else if (i_flush) begin
      for (int k = 0; k < DEPTH; k++) d[k] <= '0;
    end else if (i_en) begin
      d[0] <= i_in;
      for (int k = 1; k < DEPTH; k++) d[k] <= d[k-1];
    end
  end

  // Fill count saturates one above DEPTH so it always exceeds any threshold.
  always_comb begin
    cnt_next = cnt;
    if (i_flush) begin
      cnt_next = '0;
    end else if (shift && (cnt != CNT_MAX)) begin
      cnt_next = cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign thr = CW'(sel_cur) * CW'(T_UNIT);

  always_comb begin
    tap = i_in;
    for (int k = 1; k < NSTEP; k++) begin
      if (sel_cur == SEL_W'(k)) tap = d[k*T_UNIT-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_out <= '0;
      o_vld <= 1'b0;
    end else if (i_flush) begin
      o_out <= '0;
      o_vld <= 1'b0;
    end else if (!guard) begin
      o_out <= tap;
      o_vld <= (cnt_next > thr);
    end
  end

  assign o_sel_cur = sel_cur;
  assign o_busy    = busy;

endmodule
